// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS program loader: word width, default halt PC and
// the supervisor state encoding.
package mips_pkg;

    localparam int unsigned MIPS_W          = 32;
    localparam logic [31:0] DEFAULT_HALT_PC = 32'h0000_00FC;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StHold,
        StRun,
        StFin
    } loader_state_e;

endpackage

// File: rtl/mips_prog_loader.sv
// Program loader and run supervisor: streams words into instruction memory with the core
// held in reset, releases it, then stops on a halt PC or when the cycle budget runs out.
module mips_prog_loader
    import mips_pkg::*;
#(
    parameter int unsigned          DATA_W     = MIPS_W,
    parameter int unsigned          DEPTH      = 64,
    parameter int unsigned          ADDR_W     = $clog2(DEPTH),
    parameter logic [DATA_W-1:0]    HALT_PC    = DATA_W'(DEFAULT_HALT_PC),
    parameter int unsigned          MAX_CYCLES = 1024,
    parameter int unsigned          CYC_W      = 16,
    parameter int unsigned          RESET_HOLD = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_reset,
    input  logic [DATA_W-1:0] pc_in,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count,
    output logic [CYC_W-1:0]  cycle_count
);

    localparam int unsigned   HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [ADDR_W:0]   LAST_IDX  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(MAX_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

    loader_state_e     state_q, state_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              overflow_q, overflow_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              handshake;

    assign handshake = load_valid && (state_q == StLoad);

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        cyc_d      = cyc_q;
        hold_d     = hold_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        overflow_d = overflow_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        unique case (state_q)
            StIdle, StFin: begin
                if (start) begin
                    state_d    = StLoad;
                    word_cnt_d = '0;
                    cyc_d      = '0;
                    done_d     = 1'b0;
                    timeout_d  = 1'b0;
                    overflow_d = 1'b0;
                end
            end
            StLoad: begin
                if (handshake) begin
                    we_d       = 1'b1;
                    addr_d     = word_cnt_q[ADDR_W-1:0];
                    wdata_d    = load_data;
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (load_last) begin
                        state_d = StHold;
                        hold_d  = '0;
                    end else if (word_cnt_q == LAST_IDX) begin
                        // Memory is full and the program is still going: never wrap.
                        overflow_d = 1'b1;
                        state_d    = StFin;
                    end
                end
            end
            StHold: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = StRun;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StRun: begin
                // Halt is checked first so it wins over a same-cycle timeout.
                if (pc_in == HALT_PC) begin
                    done_d  = 1'b1;
                    state_d = StFin;
                end else if (cyc_q == CYC_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = StFin;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            word_cnt_q <= '0;
            cyc_q      <= '0;
            hold_q     <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            cyc_q      <= cyc_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // After a normal finish the core keeps spinning in its halt loop; after overflow it stays held.
    assign core_reset  = !((state_q == StRun) || ((state_q == StFin) && !overflow_q));
    assign load_ready  = (state_q == StLoad);
    assign busy        = (state_q == StLoad) || (state_q == StHold) || (state_q == StRun);
    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign overflow    = overflow_q;
    assign word_count  = word_cnt_q;
    assign cycle_count = cyc_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Bench for mips_prog_loader: table-driven sequences, hand-written reset corners and
// randomized runs checked against a small outcome model.
module tb_mips_prog_loader;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned ADDR_W     = 2;
    localparam logic [31:0] HALT_PC    = 32'd8;
    localparam int unsigned MAX_CYCLES = 20;
    localparam int unsigned CYC_W      = 16;
    localparam int unsigned RESET_HOLD = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              load_valid = 1'b0;
    logic              load_ready;
    logic [DATA_W-1:0] load_data = '0;
    logic              load_last = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              core_reset;
    logic [DATA_W-1:0] pc_in = '0;
    logic              busy, done, timeout, overflow;
    logic [ADDR_W:0]   word_count;
    logic [CYC_W-1:0]  cycle_count;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    mips_prog_loader #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .HALT_PC   (HALT_PC),
        .MAX_CYCLES(MAX_CYCLES),
        .CYC_W     (CYC_W),
        .RESET_HOLD(RESET_HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_last  (load_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .pc_in      (pc_in),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .overflow   (overflow),
        .word_count (word_count),
        .cycle_count(cycle_count)
    );

    typedef struct {
        int n_off;    // words the host offers
        int last_idx; // index carrying load_last, -1 for none
        int vmode;    // 0 always valid, 1 every other cycle, 2 random
        int halt_k;   // RUN cycle index at which PC hits HALT_PC, -1 never
        int e_words;
        bit e_done;
        bit e_to;
        bit e_ovf;
        int e_cyc;
    } vec_t;

    vec_t tbl[7];
    logic [DATA_W-1:0] prog[8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Outcome of a sequence straight from the loader's rules.
    function automatic void model(input int last_idx, input int halt_k, output int w,
                                  output bit d, output bit t, output bit o, output int c);
        o = (last_idx < 0) || (last_idx >= int'(DEPTH));
        w = o ? int'(DEPTH) : last_idx + 1;
        d = 1'b0;
        t = 1'b0;
        c = 0;
        if (!o) begin
            if (halt_k >= 0 && halt_k < int'(MAX_CYCLES)) begin
                d = 1'b1;
                c = halt_k;
            end else begin
                t = 1'b1;
                c = int'(MAX_CYCLES) - 1;
            end
        end
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_core_reset"}, core_reset, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_flags"}, {done, timeout, overflow}, 0);
        check({tag, "_imem_we"}, imem_we, 0);
        check({tag, "_load_ready"}, load_ready, 0);
        check({tag, "_counts"}, {word_count, cycle_count}, 0);
    endtask

    // Caller is between edges with the DUT in IDLE or FIN.
    task automatic run_seq(input vec_t v, input bit noise, input int abort_run);
        int w = 0, run_idx = 0, hold_n = 0, cyc_i = 0, lat_err = 0;
        bit prev_hs = 1'b0;
        int wa[$];
        logic [DATA_W-1:0] wd[$];
        for (int i = 0; i < 8; i++) prog[i] = $urandom;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_clears", {done, timeout, overflow, word_count, cycle_count}, 0);
        check("start_load_ready", load_ready, 1);
        while (1) begin
            if (imem_we !== prev_hs) lat_err++;
            if (imem_we === 1'b1) begin
                wa.push_back(int'(imem_addr));
                wd.push_back(imem_wdata);
            end
            if (!busy) break;
            pc_in = HALT_PC;  // only a RUN cycle may act on the halt PC
            if (!core_reset) begin
                if (run_idx == abort_run) begin
                    reset = 1'b0;
                    #1;
                    check_reset_values("abort");
                    load_valid = 1'b0;
                    @(negedge clk);
                    reset = 1'b1;
                    return;
                end
                pc_in = (run_idx == v.halt_k) ? HALT_PC : HALT_PC + 32'(4 * (run_idx + 1));
                run_idx++;
            end else if (!load_ready) begin
                hold_n++;
            end
            load_valid = 1'b0;
            load_last  = 1'b0;
            if (load_ready && w < v.n_off) begin
                case (v.vmode)
                    0:       load_valid = 1'b1;
                    1:       load_valid = (cyc_i % 2 == 0);
                    default: load_valid = 1'($urandom % 2);
                endcase
                load_data = prog[w];
                load_last = (w == v.last_idx);
            end
            start = noise ? 1'($urandom % 2) : 1'b0;
            prev_hs = load_valid && load_ready;
            @(posedge clk); #1;
            if (prev_hs) w++;
            cyc_i++;
            if (cyc_i > 400) begin
                check("cycle_budget", cyc_i, 400);
                break;
            end
        end
        start = 1'b0;
        load_valid = 1'b0;
        load_last = 1'b0;
        check("write_latency_errors", lat_err, 0);
        check("write_count", wa.size(), v.e_words);
        for (int i = 0; i < wa.size() && i < v.e_words; i++) begin
            check("write_addr", wa[i], i);
            check("write_data", wd[i], prog[i]);
        end
        check("word_count", word_count, v.e_words);
        check("cycle_count", cycle_count, v.e_cyc);
        check("done", done, v.e_done);
        check("timeout", timeout, v.e_to);
        check("overflow", overflow, v.e_ovf);
        check("fin_core_reset", core_reset, v.e_ovf);
        check("fin_load_ready", load_ready, 0);
        check("hold_cycles", hold_n, v.e_ovf ? 0 : RESET_HOLD);
        check("run_cycles", run_idx, v.e_ovf ? 0 : v.e_cyc + 1);
    endtask

    initial begin
        vec_t rv;
        //        n  last vm halt words done to ovf cyc
        tbl[0] = '{3, 2,  0, 2,   3,    1,   0, 0,  2};
        tbl[1] = '{3, 2,  1, 2,   3,    1,   0, 0,  2};
        tbl[2] = '{3, 2,  0, -1,  3,    0,   1, 0,  19};
        tbl[3] = '{5, -1, 0, 2,   4,    0,   0, 1,  0};
        tbl[4] = '{3, 2,  2, 19,  3,    1,   0, 0,  19};
        tbl[5] = '{4, 3,  0, 0,   4,    1,   0, 0,  0};
        tbl[6] = '{1, 0,  1, 20,  1,    0,   1, 0,  19};

        #12;
        check_reset_values("por");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_seq(tbl[i], 1'b0, -1);

        // start pulses while busy must be ignored
        run_seq(tbl[4], 1'b1, -1);

        // Reset during RUN cycle 5, then a clean reload from address 0.
        run_seq(tbl[2], 1'b0, 5);
        @(posedge clk); #1;
        run_seq(tbl[0], 1'b0, -1);

        // Reset with a write in flight drops it at once.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        load_valid = 1'b1;
        load_data = 32'hDEAD_BEEF;
        load_last = 1'b0;
        @(posedge clk); #1;
        load_valid = 1'b0;
        check("inflight_we", imem_we, 1);
        reset = 1'b0;
        #1;
        check_reset_values("inflight");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int r = 0; r < 30; r++) begin
            rv.n_off = $urandom_range(1, 6);
            if (rv.n_off > int'(DEPTH) && ($urandom % 2 == 1)) rv.last_idx = -1;
            else rv.last_idx = $urandom_range(0, rv.n_off - 1);
            rv.vmode  = $urandom_range(0, 2);
            rv.halt_k = $urandom_range(0, 24);
            model(rv.last_idx, rv.halt_k, rv.e_words, rv.e_done, rv.e_to, rv.e_ovf, rv.e_cyc);
            run_seq(rv, 1'($urandom % 2), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/mips_prog_loader.md
Name: mips_prog_loader

Overview:
Parametrised program loader and run supervisor for the single-cycle MIPS core. It replaces hierarchical pokes into instruction memory with a valid/ready load stream and writes words into the instruction-memory write port. It holds the core in reset while loading, releases it, then watches the PC for a halt address or a cycle-budget timeout. Sits between the test/boot host and the MIPS core plus its instruction memory.

Parameters:
DATA_W, 32, instruction word width and PC width.
DEPTH, 64, instruction memory depth in words; power of two, minimum 2.
ADDR_W, $clog2(DEPTH), word-index width; derived, do not override.
HALT_PC, 32'h0000_00FC, byte PC value that signals program completion (self-branch loop).
MAX_CYCLES, 1024, run-cycle budget before timeout; minimum 1.
CYC_W, 16, cycle counter width; must satisfy 2^CYC_W > MAX_CYCLES.
RESET_HOLD, 2, cycles core_reset stays high after loading completes; minimum 1.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset of this block
start  in  1  one-cycle pulse; begins a load/run sequence
load_valid  in  1  load word present
load_ready  out  1  loader accepts a word this cycle
load_data  in  DATA_W  instruction word
load_last  in  1  marks final word of the program
imem_we  out  1  instruction memory write enable
imem_addr  out  ADDR_W  word index written
imem_wdata  out  DATA_W  word written
core_reset  out  1  active-high reset to the MIPS core
pc_in  in  DATA_W  core PC (byte address)
busy  out  1  high in LOAD, HOLD, RUN
done  out  1  sticky: halt PC reached
timeout  out  1  sticky: cycle budget exhausted
overflow  out  1  sticky: more than DEPTH words offered without load_last
word_count  out  ADDR_W+1  words written in current sequence
cycle_count  out  CYC_W  core cycles run in current sequence

Behaviour:
- Reset (reset low, async): state IDLE; core_reset=1; load_ready=0; imem_we=0; imem_addr=0; imem_wdata=0; busy=0; done=timeout=overflow=0; word_count=0; cycle_count=0.
- States IDLE, LOAD, HOLD, RUN, FIN.
- IDLE: core_reset=1. start -> LOAD; clear word_count, cycle_count and all flags on the same edge.
- LOAD: core_reset=1; load_ready=1 combinationally. Handshake = load_valid & load_ready. On handshake, registered write next cycle: imem_we=1, imem_addr=word_count[ADDR_W-1:0], imem_wdata=load_data; word_count increments. Write latency 1 cycle; at most one write per cycle; imem_we low otherwise.
- LOAD exit: handshake with load_last -> HOLD. Handshake of word index DEPTH-1 without load_last -> overflow=1, -> FIN (core stays in reset, no run); load_ready drops the next cycle. No address wrap ever occurs.
- HOLD: core_reset=1 for exactly RESET_HOLD cycles (internal counter), then -> RUN; core_reset=0 from the first RUN cycle.
- RUN: cycle_count increments each cycle. pc_in==HALT_PC -> done=1, -> FIN. cycle_count==MAX_CYCLES-1 without halt -> timeout=1, -> FIN. Both in same cycle: done wins, timeout stays 0.
- FIN: flags and counters hold; busy=0. After done/timeout core_reset stays 0 (core spins in halt loop; state remains inspectable). After overflow core_reset=1.
- start ignored in LOAD, HOLD, RUN. start in IDLE or FIN restarts: clear flags and counters, -> LOAD.
- Reset mid-sequence: immediate return to reset values; any in-flight imem write dropped (imem_we=0 asynchronously).

Decomposition:
- Shared package mips_pkg: state enum encoding (IDLE..FIN), default HALT_PC, MIPS word width constant.
- No sub-module needed; one optional small down-counter module hold_counter for HOLD is acceptable but inline is preferred.

Test Plan:
- 3-word program (ADD, SUB, BEQ self-loop at word 2), HALT_PC=8, load_valid always high, start pulse -> imem writes addr 0,1,2 on consecutive cycles; HOLD 2 cycles; done=1 on PC==8; timeout=0; word_count=3.
- Same program with load_valid toggling every other cycle -> writes only on handshake cycles, addresses contiguous 0,1,2, word_count=3.
- Program with no halt, MAX_CYCLES=20 -> timeout=1 after exactly 20 RUN cycles, done=0, cycle_count=19.
- DEPTH=4, 5 words offered, no load_last -> 4 writes (addr 0..3), overflow=1, core_reset remains 1, load_ready 0 afterwards.
- reset low during RUN cycle 5 -> core_reset=1, busy=0, all flags 0 immediately; subsequent start reloads cleanly from addr 0.
- PC reaches HALT_PC on cycle MAX_CYCLES-1 -> done=1, timeout=0; start in FIN clears flags and re-enters LOAD.
